ehgu_sfifo: RTL and testbench
=============================

EHGU_SFIFO -- requirements
Module: ehgu_sfifo

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Parameter WIDTH, default 8, SHALL set the data word width in bits; legal values are 1 or more.
REQ-003 Parameter DEPTH, default 128, SHALL set the word capacity; it must be a power of 2 and at least 2.
REQ-004 Parameter FWFT, default 1, SHALL select first-word-fall-through mode (1) or registered-read mode (0).
REQ-005 Parameter AF_LVL, default DEPTH-2, SHALL set the almost_full threshold.
REQ-006 Parameter AE_LVL, default 2, SHALL set the almost_empty threshold.
REQ-007 AWIDTH SHALL be a localparam equal to $clog2(DEPTH).
REQ-008 clk0 SHALL be a 1-bit input, the rising-edge clock.
REQ-009 rst SHALL be a 1-bit input, the synchronous active-high reset.
REQ-010 flush SHALL be a 1-bit input that empties the FIFO synchronously.
REQ-011 clr_err SHALL be a 1-bit input that clears the sticky error flags.
REQ-012 din_valid SHALL be a 1-bit input, the write request.
REQ-013 din_ready SHALL be a 1-bit output, asserted when the FIFO can accept a write.
REQ-014 din SHALL be a WIDTH-bit input, the write data.
REQ-015 dout_valid SHALL be a 1-bit output, asserted when dout holds valid read data.
REQ-016 dout_ready SHALL be a 1-bit input: the pop acknowledge when FWFT=1, the read request when FWFT=0.
REQ-017 dout SHALL be a WIDTH-bit output, the read data.
REQ-018 count SHALL be an AWIDTH+1-bit output giving the number of stored words.
REQ-019 full, empty, almost_full and almost_empty SHALL each be a 1-bit status output.
REQ-020 ovf and udf SHALL each be a 1-bit sticky error output.

Function
REQ-021 Storage SHALL be a DEPTH x WIDTH array addressed by AWIDTH-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-022 count SHALL update every cycle as +1 on push only, -1 on pop only, and unchanged on push and pop together.
REQ-023 Status SHALL be registered-consistent: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LVL), almost_empty = (count<=AE_LVL).
REQ-024 din_ready SHALL equal !full, with no combinational path from dout_ready.
REQ-025 A push SHALL occur when din_valid && din_ready; din is written at the write pointer and the write pointer increments.
REQ-026 din_valid && !din_ready SHALL drop the word and set ovf.
REQ-027 With FWFT=1, dout_valid SHALL equal !empty and dout SHALL present the head word.
REQ-028 With FWFT=1, a pop SHALL occur when dout_valid && dout_ready.
REQ-029 With FWFT=1, a word pushed into an empty FIFO SHALL appear on dout with dout_valid=1 in the next cycle.
REQ-030 With FWFT=1, udf SHALL never be set.
REQ-031 With FWFT=0, a pop SHALL occur when dout_ready && !empty.
REQ-032 With FWFT=0, dout SHALL be registered: one cycle after a pop, dout_valid=1 for exactly one cycle and dout holds the popped word until the next pop.
REQ-033 With FWFT=0, dout_ready && empty SHALL set udf and produce no dout_valid.
REQ-034 A push and a pop in the same cycle when not full SHALL both complete, leaving count unchanged.
REQ-035 A push and a pop in the same cycle when full SHALL complete the pop only, because din_ready=0.
REQ-036 A push and a pop in the same cycle when empty SHALL complete the push only.
REQ-037 flush SHALL zero both pointers and count and clear dout_valid in the same edge, overriding any coincident push or pop, and SHALL leave ovf, udf and the memory contents unchanged.
REQ-038 clr_err SHALL clear ovf and udf; if an error event occurs in the same cycle, the flag SHALL remain set.

Reset
REQ-039 On rst=1 at a clk0 edge, the pointers, count, dout_valid, ovf and udf SHALL be set to 0.
REQ-040 On the same reset, dout SHALL be set to 0 when FWFT=0.
REQ-041 After reset the outputs SHALL read empty=1, full=0, din_ready=1, almost_empty=1 and almost_full=0.
REQ-042 Reset SHALL have priority over flush, clr_err, push and pop.
REQ-043 The memory array SHALL NOT be reset.
REQ-044 Reset asserted mid-stream SHALL discard all stored words.

Verification (DEPTH=4, WIDTH=8, AF_LVL=3, AE_LVL=1)
REQ-045 FWFT=1, push 0xA1..0xA4 on consecutive cycles -> count 1,2,3,4; almost_full=1 at count 3, full=1 at count 4; a fifth push of 0xA5 -> din_ready=0, ovf=1, and pops return A1,A2,A3,A4 in order.
REQ-046 FWFT=1, push 0x55 into empty -> dout_valid=1 and dout=0x55 next cycle; with dout_ready held, push and pop every cycle for 10 cycles -> count holds 1 and the pointers wrap cleanly.
REQ-047 FWFT=0, push 0x11 and 0x22, then dout_ready for 3 cycles -> dout_valid pulses with 0x11 then 0x22, udf=1 on the third request, and clr_err -> udf=0.
REQ-048 Fill 3 words, assert flush together with din_valid -> count=0, empty=1 and the pushed word is discarded; ovf is unchanged.
REQ-049 Fill 2 words and assert rst with dout_ready=1 -> next cycle count=0, dout_valid=0, ovf=0 and udf=0.
REQ-050 Fill to full, then push and pop in the same cycle -> only the pop is taken and count goes from 4 to 3.

Source files
------------

// File: rtl/ehgu_sfifo.sv
// Synchronous single-clock FIFO with selectable first-word-fall-through or
// registered read, occupancy count, almost/full/empty flags and sticky errors.
module ehgu_sfifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 128,
  parameter int FWFT   = 1,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic                        clk0,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        clr_err,
  input  logic                        din_valid,
  output logic                        din_ready,
  input  logic [WIDTH-1:0]            din,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [WIDTH-1:0]            dout,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic                        ovf,
  output logic                        udf
);

  localparam int AWIDTH = $clog2(DEPTH);
  localparam int CW     = AWIDTH + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LVL);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wptr;
  logic [AWIDTH-1:0] r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic              r_udf;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_ovf_evt;
  logic w_udf_evt;

  // Flags derive only from the registered count, so din_ready never sees dout_ready.
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = din_valid && !w_full;
  assign w_pop     = dout_ready && !w_empty;
  assign w_ovf_evt = din_valid && w_full;
  assign w_udf_evt = (FWFT == 0) && dout_ready && w_empty;

  assign din_ready    = !w_full;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);
  assign count        = r_count;
  assign ovf          = r_ovf;
  assign udf          = r_udf;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk0) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A coincident error event wins over clr_err; flush does not raise errors.
  always_ff @(posedge clk0) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf && !clr_err) || (w_ovf_evt && !flush);
      r_udf <= (r_udf && !clr_err) || (w_udf_evt && !flush);
    end
  end

  // NOTE: the storage array has no reset; pointers and count define validity,
  // which keeps it mappable onto plain RAM.
  always_ff @(posedge clk0) begin
    if (w_push && !flush) r_mem[r_wptr] <= din;
  end

  if (FWFT != 0) begin : g_fwft
    assign dout_valid = !w_empty;
    assign dout       = r_mem[r_rptr];
  end else begin : g_regread
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;

    always_ff @(posedge clk0) begin
      if (rst) begin
        r_dout       <= '0;
        r_dout_valid <= 1'b0;
      end else if (flush) begin
        r_dout_valid <= 1'b0;
      end else begin
        r_dout_valid <= w_pop;
        if (w_pop) r_dout <= r_mem[r_rptr];
      end
    end

    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
  end

endmodule

// File: tb/tb_ehgu_sfifo.sv
// Scoreboard bench for ehgu_sfifo: one FWFT instance and one registered-read
// instance, DEPTH=4, WIDTH=8, AF_LVL=3, AE_LVL=1.
module tb_ehgu_sfifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  // FWFT=1 instance
  logic       a_rst = 1'b0, a_flush = 1'b0, a_clr = 1'b0, a_vin = 1'b0, a_rin = 1'b0;
  logic [7:0] a_din = '0;
  logic       a_rdy, a_vout, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [7:0] a_dout;
  logic [2:0] a_count;

  // FWFT=0 instance
  logic       b_rst = 1'b0, b_flush = 1'b0, b_clr = 1'b0, b_vin = 1'b0, b_rin = 1'b0;
  logic [7:0] b_din = '0;
  logic       b_rdy, b_vout, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [7:0] b_dout;
  logic [2:0] b_count;

  ehgu_sfifo #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AF_LVL(3), .AE_LVL(1)) u_dut_a (
    .clk0(clk), .rst(a_rst), .flush(a_flush), .clr_err(a_clr),
    .din_valid(a_vin), .din_ready(a_rdy), .din(a_din),
    .dout_valid(a_vout), .dout_ready(a_rin), .dout(a_dout),
    .count(a_count), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .ovf(a_ovf), .udf(a_udf)
  );

  ehgu_sfifo #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AF_LVL(3), .AE_LVL(1)) u_dut_b (
    .clk0(clk), .rst(b_rst), .flush(b_flush), .clr_err(b_clr),
    .din_valid(b_vin), .din_ready(b_rdy), .din(b_din),
    .dout_valid(b_vout), .dout_ready(b_rin), .dout(b_dout),
    .count(b_count), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .ovf(b_ovf), .udf(b_udf)
  );

  // Advance one edge; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a write on instance A for one cycle and record it when accepted.
  task automatic push_a(input logic [7:0] d);
    a_vin = 1'b1;
    a_din = d;
    if (a_count < 3'd4) q_a.push_back(d);
    tick();
    a_vin = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    b_vin = 1'b1;
    b_din = d;
    if (b_count < 3'd4) q_b.push_back(d);
    tick();
    b_vin = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] got, exp;
    a_rst = 1'b1; b_rst = 1'b1;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;
    // {count, full, empty, af, ae, din_ready, dout_valid, ovf, udf}
    exp = {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    got = {a_count, a_full, a_empty, a_af, a_ae, a_rdy, a_vout, a_ovf, a_udf};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_a status got=%b exp=%b", got, exp);
    end
    got = {b_count, b_full, b_empty, b_af, b_ae, b_rdy, b_vout, b_ovf, b_udf};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_b status got=%b exp=%b", got, exp);
    end
    checks++;
    if (b_dout !== 8'h00) begin
      failures++;
      $display("FAIL reset_b dout got=%h exp=00", b_dout);
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      push_a(8'hA1 + 8'(i));
      checks++;
      if (a_count !== 3'(i + 1) || a_af !== (i >= 2) || a_full !== (i == 3)) begin
        failures++;
        $display("FAIL fill count/af/full got=%0d/%b/%b exp=%0d/%b/%b",
                 a_count, a_af, a_full, i + 1, (i >= 2), (i == 3));
      end
    end
    checks++;
    if (a_rdy !== 1'b0) begin
      failures++;
      $display("FAIL full_din_ready got=%b exp=0", a_rdy);
    end
    push_a(8'hA5);
    checks++;
    if (a_ovf !== 1'b1 || a_count !== 3'd4) begin
      failures++;
      $display("FAIL overflow ovf/count got=%b/%0d exp=1/4", a_ovf, a_count);
    end
    a_rin = 1'b1;
    while (q_a.size() > 0) begin
      exp = q_a.pop_front();
      checks++;
      if (a_vout !== 1'b1 || a_dout !== exp) begin
        failures++;
        $display("FAIL drain_order got=%b/%h exp=1/%h", a_vout, a_dout, exp);
      end
      tick();
    end
    a_rin = 1'b0;
    checks++;
    if (a_empty !== 1'b1 || a_vout !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty empty/vout got=%b/%b exp=1/0", a_empty, a_vout);
    end
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    checks++;
    if (a_ovf !== 1'b0) begin
      failures++;
      $display("FAIL clr_ovf got=%b exp=0", a_ovf);
    end
  endtask

  task automatic test_fwft_stream();
    logic [7:0] exp;
    // Push into empty while dout_ready is already high: only the push happens.
    a_rin = 1'b1;
    push_a(8'h55);
    checks++;
    if (a_vout !== 1'b1 || a_dout !== 8'h55 || a_count !== 3'd1) begin
      failures++;
      $display("FAIL fwft_first vout/dout/count got=%b/%h/%0d exp=1/55/1", a_vout, a_dout, a_count);
    end
    for (int i = 0; i < 10; i++) begin
      exp = q_a.pop_front();
      checks++;
      if (a_dout !== exp) begin
        failures++;
        $display("FAIL stream_dout[%0d] got=%h exp=%h", i, a_dout, exp);
      end
      push_a(8'h60 + 8'(i));
      checks++;
      if (a_count !== 3'd1) begin
        failures++;
        $display("FAIL stream_count[%0d] got=%0d exp=1", i, a_count);
      end
    end
    exp = q_a.pop_front();
    checks++;
    if (a_dout !== exp) begin
      failures++;
      $display("FAIL stream_last got=%h exp=%h", a_dout, exp);
    end
    tick();
    tick();
    a_rin = 1'b0;
    checks++;
    if (a_empty !== 1'b1 || a_udf !== 1'b0) begin
      failures++;
      $display("FAIL fwft_no_udf empty/udf got=%b/%b exp=1/0", a_empty, a_udf);
    end
  endtask

  task automatic test_registered_read();
    logic [7:0] exp;
    push_b(8'h11);
    push_b(8'h22);
    checks++;
    if (b_vout !== 1'b0) begin
      failures++;
      $display("FAIL regread_idle_valid got=%b exp=0", b_vout);
    end
    b_rin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = q_b.pop_front();
      checks++;
      if (b_vout !== 1'b1 || b_dout !== exp) begin
        failures++;
        $display("FAIL regread[%0d] vout/dout got=%b/%h exp=1/%h", i, b_vout, b_dout, exp);
      end
    end
    tick();
    b_rin = 1'b0;
    checks++;
    if (b_udf !== 1'b1 || b_vout !== 1'b0 || b_dout !== 8'h22) begin
      failures++;
      $display("FAIL underflow udf/vout/dout got=%b/%b/%h exp=1/0/22", b_udf, b_vout, b_dout);
    end
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    checks++;
    if (b_udf !== 1'b0) begin
      failures++;
      $display("FAIL clr_udf got=%b exp=0", b_udf);
    end
  endtask

  task automatic test_flush();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) push_a(8'hC0 + 8'(i));
    push_a(8'hCF);
    a_rin = 1'b1;
    void'(q_a.pop_front());
    tick();
    a_rin = 1'b0;
    checks++;
    if (a_count !== 3'd3 || a_ovf !== 1'b1) begin
      failures++;
      $display("FAIL preflush count/ovf got=%0d/%b exp=3/1", a_count, a_ovf);
    end
    a_flush = 1'b1;
    a_vin   = 1'b1;
    a_din   = 8'hDD;
    tick();
    a_flush = 1'b0;
    a_vin   = 1'b0;
    q_a.delete();
    checks++;
    if (a_count !== 3'd0 || a_empty !== 1'b1 || a_vout !== 1'b0 || a_ovf !== 1'b1) begin
      failures++;
      $display("FAIL flush count/empty/vout/ovf got=%0d/%b/%b/%b exp=0/1/0/1",
               a_count, a_empty, a_vout, a_ovf);
    end
    push_a(8'h77);
    exp = q_a.pop_front();
    checks++;
    if (a_dout !== exp || a_count !== 3'd1) begin
      failures++;
      $display("FAIL postflush dout/count got=%h/%0d exp=%h/1", a_dout, a_count, exp);
    end
    a_rin = 1'b1;
    a_clr = 1'b1;
    tick();
    a_rin = 1'b0;
    a_clr = 1'b0;
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 4; i++) push_b(8'h30 + 8'(i));
    push_b(8'h3F);
    checks++;
    if (b_ovf !== 1'b1 || b_full !== 1'b1) begin
      failures++;
      $display("FAIL prereset ovf/full got=%b/%b exp=1/1", b_ovf, b_full);
    end
    b_rst = 1'b1;
    b_rin = 1'b1;
    b_vin = 1'b1;
    tick();
    b_rst = 1'b0;
    b_rin = 1'b0;
    b_vin = 1'b0;
    q_b.delete();
    checks++;
    if (b_count !== 3'd0 || b_vout !== 1'b0 || b_ovf !== 1'b0 || b_udf !== 1'b0 || b_dout !== 8'h00) begin
      failures++;
      $display("FAIL midreset count/vout/ovf/udf/dout got=%0d/%b/%b/%b/%h exp=0/0/0/0/00",
               b_count, b_vout, b_ovf, b_udf, b_dout);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) push_a(8'hE0 + 8'(i));
    checks++;
    if (a_count !== 3'd4 || a_rdy !== 1'b0) begin
      failures++;
      $display("FAIL prefull count/din_ready got=%0d/%b exp=4/0", a_count, a_rdy);
    end
    a_rin = 1'b1;
    exp = q_a.pop_front();
    checks++;
    if (a_dout !== exp) begin
      failures++;
      $display("FAIL full_pushpop_dout got=%h exp=%h", a_dout, exp);
    end
    push_a(8'hEE);
    checks++;
    if (a_count !== 3'd3 || a_ovf !== 1'b1) begin
      failures++;
      $display("FAIL full_pushpop count/ovf got=%0d/%b exp=3/1", a_count, a_ovf);
    end
    while (q_a.size() > 0) begin
      exp = q_a.pop_front();
      checks++;
      if (a_dout !== exp) begin
        failures++;
        $display("FAIL full_drain got=%h exp=%h", a_dout, exp);
      end
      tick();
    end
    a_rin = 1'b0;
    checks++;
    if (a_empty !== 1'b1) begin
      failures++;
      $display("FAIL full_drain_empty got=%b exp=1", a_empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_fwft_stream();
    test_registered_read();
    test_flush();
    test_reset_midstream();
    test_full_push_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
